// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the MEM/WB pipeline register and its load formatter.
// Defines the datapath width, the retired-instruction counter width, result-select
// and load-type encodings, and the byte/half extension helpers.
package rv32_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 64;

  // Writeback result mux select
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  // Load type (funct3 of the load opcode)
  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } load_funct3_e;

  // Widen a byte to XLEN, sign- or zero-filling the upper bits
  function automatic logic [XLEN-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    return {{(XLEN-8){sgn & b[7]}}, b};
  endfunction

  // Widen a halfword to XLEN, sign- or zero-filling the upper bits
  function automatic logic [XLEN-1:0] ext_half(input logic [15:0] h, input logic sgn);
    return {{(XLEN-16){sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_wb_reg_if.sv
// MEM->WB stage bus: M-stage inputs plus stall/flush controls, and W-stage outputs.
// master = the pipeline side driving the M stage; slave = the MEM/WB register.
// InstRetW_o is present only when MEMWB_INSTRET_EN is defined.
interface mem_wb_reg_if;
  import rv32_pkg::*;

  // Controls
  logic            EnW_i;
  logic            FlushW_i;
  // M-stage inputs
  logic            ValidM_i;
  logic            RegWriteM_i;
  logic [1:0]      ResultSrcM_i;
  logic [2:0]      Funct3M_i;
  logic [XLEN-1:0] ALUResultM_i;
  logic [XLEN-1:0] ReadDataM_i;
  logic [XLEN-1:0] PCPlus4M_i;
  logic [4:0]      RdM_i;
  // W-stage outputs
  logic            ValidW_o;
  logic            RegWriteW_o;
  logic [1:0]      ResultSrcW_o;
  logic [XLEN-1:0] ALUResultW_o;
  logic [XLEN-1:0] ReadDataW_o;
  logic [XLEN-1:0] PCPlus4W_o;
  logic [4:0]      RdW_o;
`ifdef MEMWB_INSTRET_EN
  logic [CNT_W-1:0] InstRetW_o;
`endif

  modport master (
    output EnW_i, FlushW_i, ValidM_i, RegWriteM_i, ResultSrcM_i, Funct3M_i,
    output ALUResultM_i, ReadDataM_i, PCPlus4M_i, RdM_i,
`ifdef MEMWB_INSTRET_EN
    input  InstRetW_o,
`endif
    input  ValidW_o, RegWriteW_o, ResultSrcW_o, ALUResultW_o, ReadDataW_o,
    input  PCPlus4W_o, RdW_o
  );

  modport slave (
    input  EnW_i, FlushW_i, ValidM_i, RegWriteM_i, ResultSrcM_i, Funct3M_i,
    input  ALUResultM_i, ReadDataM_i, PCPlus4M_i, RdM_i,
`ifdef MEMWB_INSTRET_EN
    output InstRetW_o,
`endif
    output ValidW_o, RegWriteW_o, ResultSrcW_o, ALUResultW_o, ReadDataW_o,
    output PCPlus4W_o, RdW_o
  );

endinterface

// File: rtl/load_ext.sv
// Load formatter: selects byte/half from the aligned memory word and sign/zero extends.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs.
module load_ext
  import rv32_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and half; off_i[0] is ignored for halves (no misalign trap)
  always_comb begin
    byte_sel = word_i[7:0];
    case (off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // Extend per load type; unknown funct3 passes the raw word through
  always_comb begin
    data_o = word_i;
    case (funct3_i)
      LD_LB:   data_o = ext_byte(byte_sel, 1'b1);
      LD_LBU:  data_o = ext_byte(byte_sel, 1'b0);
      LD_LH:   data_o = ext_half(half_sel, 1'b1);
      LD_LHU:  data_o = ext_half(half_sel, 1'b0);
      LD_LW:   data_o = word_i;
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM->WB pipeline register; formats load data before registering. Optional counter: MEMWB_INSTRET_EN.
// Latency: 1 cycle from an edge with EnW_i=1, FlushW_i=0.
// Backpressure: EnW_i=0 stalls (all state holds); FlushW_i inserts a bubble and wins over EnW_i.
module mem_wb_reg
  import rv32_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  mem_wb_reg_if.slave  bus
);

  logic [XLEN-1:0] ext_data;

  load_ext u_load_ext (
    .funct3_i (bus.Funct3M_i),
    .off_i    (bus.ALUResultM_i[1:0]),
    .word_i   (bus.ReadDataM_i),
    .data_o   (ext_data)
  );

  // Control registers (cleared by flush)
  logic            valid_q,      valid_d;
  logic            regwrite_q,   regwrite_d;
  logic [1:0]      result_src_q, result_src_d;
  logic [4:0]      rd_q,         rd_d;
  // Data registers (held through flush)
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] read_data_q,  read_data_d;
  logic [XLEN-1:0] pc_plus4_q,   pc_plus4_d;

  // Next-state: flush clears control only, enable loads everything, otherwise hold
  always_comb begin
    valid_d      = valid_q;
    regwrite_d   = regwrite_q;
    result_src_d = result_src_q;
    rd_d         = rd_q;
    alu_result_d = alu_result_q;
    read_data_d  = read_data_q;
    pc_plus4_d   = pc_plus4_q;
    if (bus.FlushW_i) begin
      valid_d      = 1'b0;
      regwrite_d   = 1'b0;
      result_src_d = RES_ALU;
      rd_d         = 5'd0;
    end else if (bus.EnW_i) begin
      valid_d      = bus.ValidM_i;
      // x0 writes are dropped here so writeback never sees them
      regwrite_d   = bus.RegWriteM_i & bus.ValidM_i & (bus.RdM_i != 5'd0);
      result_src_d = bus.ResultSrcM_i;
      rd_d         = bus.RdM_i;
      alu_result_d = bus.ALUResultM_i;
      read_data_d  = ext_data;
      pc_plus4_d   = bus.PCPlus4M_i;
    end
  end

  // Stage registers with asynchronous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      result_src_q <= 2'b00;
      rd_q         <= 5'd0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      pc_plus4_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      regwrite_q   <= regwrite_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      pc_plus4_q   <= pc_plus4_d;
    end
  end

  assign bus.ValidW_o     = valid_q;
  assign bus.RegWriteW_o  = regwrite_q;
  assign bus.ResultSrcW_o = result_src_q;
  assign bus.RdW_o        = rd_q;
  assign bus.ALUResultW_o = alu_result_q;
  assign bus.ReadDataW_o  = read_data_q;
  assign bus.PCPlus4W_o   = pc_plus4_q;

`ifdef MEMWB_INSTRET_EN
  logic [CNT_W-1:0] instret_q, instret_d;

  // Count real instructions entering writeback; wraps naturally at 2^CNT_W
  always_comb begin
    instret_d = instret_q;
    if (!bus.FlushW_i && bus.EnW_i && bus.ValidM_i) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  // Counter register with asynchronous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign bus.InstRetW_o = instret_q;
`endif

endmodule

// File: tb/tb_mem_wb_reg.sv
// Scoreboard bench for mem_wb_reg: the driver pushes the expected W-stage state for each
// edge it drives; a monitor pops and compares after every rising edge.
// Async reset, load extension, x0 gating, stall/flush and the optional counter are covered.
module tb_mem_wb_reg;
  import rv32_pkg::*;

  typedef struct packed {
    logic             valid;
    logic             rw;
    logic [1:0]       src;
    logic [31:0]      alu;
    logic [31:0]      rdata;
    logic [31:0]      pc4;
    logic [4:0]       rd;
    logic [CNT_W-1:0] instret;
  } exp_t;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [1:0]  src;
    logic        valid;
    logic        rwm;
    logic [4:0]  rd;
    logic [31:0] exp_rdata;
    logic        exp_rw;
  } vec_t;

`ifdef MEMWB_INSTRET_EN
  localparam bit HAS_CNT = 1'b1;
`else
  localparam bit HAS_CNT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_wb_reg_if bus();

  mem_wb_reg u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  exp_t sb[$];
  exp_t model;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vt[12];

  function automatic exp_t snap();
    exp_t s;
    s.valid = bus.ValidW_o;
    s.rw    = bus.RegWriteW_o;
    s.src   = bus.ResultSrcW_o;
    s.alu   = bus.ALUResultW_o;
    s.rdata = bus.ReadDataW_o;
    s.pc4   = bus.PCPlus4W_o;
    s.rd    = bus.RdW_o;
`ifdef MEMWB_INSTRET_EN
    s.instret = bus.InstRetW_o;
`else
    s.instret = '0;
`endif
    return s;
  endfunction

  task automatic check_state(input string name, input exp_t act, input exp_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got v=%b rw=%b src=%h alu=%h rdata=%h pc4=%h rd=%0d cnt=%0h, want v=%b rw=%b src=%h alu=%h rdata=%h pc4=%h rd=%0d cnt=%0h",
               name, act.valid, act.rw, act.src, act.alu, act.rdata, act.pc4, act.rd, act.instret,
               exp.valid, exp.rw, exp.src, exp.alu, exp.rdata, exp.pc4, exp.rd, exp.instret);
    end
  endtask

  task automatic check_val(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitor: compare DUT state after each rising edge against the next queued expectation
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() != 0) begin
        check_state("scoreboard", snap(), sb.pop_front());
      end
    end
  end

  // Drive one edge's worth of inputs at the falling edge and queue the expected result
  task automatic drive_edge(input logic en, input logic flush, input vec_t v);
    @(negedge clk);
    bus.EnW_i        = en;
    bus.FlushW_i     = flush;
    bus.ValidM_i     = v.valid;
    bus.RegWriteM_i  = v.rwm;
    bus.ResultSrcM_i = v.src;
    bus.Funct3M_i    = v.f3;
    bus.ALUResultM_i = v.alu;
    bus.ReadDataM_i  = v.rdata;
    bus.PCPlus4M_i   = v.pc4;
    bus.RdM_i        = v.rd;
    if (flush) begin
      model.valid = 1'b0;
      model.rw    = 1'b0;
      model.rd    = 5'd0;
      model.src   = 2'b00;
    end else if (en) begin
      model.valid = v.valid;
      model.rw    = v.exp_rw;
      model.src   = v.src;
      model.alu   = v.alu;
      model.rdata = v.exp_rdata;
      model.pc4   = v.pc4;
      model.rd    = v.rd;
      if (HAS_CNT && v.valid) model.instret = model.instret + 1'b1;
    end
    sb.push_back(model);
  endtask

  task automatic wait_drain();
    int budget;
    budget = 50;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #3;
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    //        f3      alu            rdata          pc4            src    v     rw    rd     exp_rdata      exp_rw
    vt[0]  = '{3'b000, 32'h0000_1001, 32'h1234_80FF, 32'h0000_0104, 2'b01, 1'b1, 1'b1, 5'd3,  32'hFFFF_FF80, 1'b1};
    vt[1]  = '{3'b101, 32'h0000_2002, 32'h1234_80FF, 32'h0000_0108, 2'b01, 1'b1, 1'b1, 5'd0,  32'h0000_1234, 1'b0};
    vt[2]  = '{3'b010, 32'h0000_3003, 32'h1234_80FF, 32'h0000_010C, 2'b01, 1'b1, 1'b1, 5'd5,  32'h1234_80FF, 1'b1};
    vt[3]  = '{3'b100, 32'h0000_4000, 32'h1234_80FF, 32'h0000_0110, 2'b01, 1'b1, 1'b0, 5'd7,  32'h0000_00FF, 1'b0};
    vt[4]  = '{3'b001, 32'h0000_5001, 32'h1234_80FF, 32'h0000_0114, 2'b01, 1'b0, 1'b1, 5'd9,  32'hFFFF_80FF, 1'b0};
    vt[5]  = '{3'b000, 32'h0000_6003, 32'h1234_80FF, 32'h0000_0118, 2'b01, 1'b1, 1'b1, 5'd31, 32'h0000_0012, 1'b1};
    vt[6]  = '{3'b001, 32'h0000_7002, 32'h8001_7FFF, 32'h0000_011C, 2'b01, 1'b1, 1'b1, 5'd1,  32'hFFFF_8001, 1'b1};
    vt[7]  = '{3'b011, 32'h0000_8003, 32'hDEAD_BEEF, 32'h0000_0120, 2'b00, 1'b1, 1'b1, 5'd2,  32'hDEAD_BEEF, 1'b1};
    vt[8]  = '{3'b000, 32'h0000_9002, 32'hDEAD_BEEF, 32'h0000_0124, 2'b10, 1'b1, 1'b1, 5'd4,  32'hFFFF_FFAD, 1'b1};
    vt[9]  = '{3'b101, 32'h0000_A000, 32'hDEAD_BEEF, 32'h0000_0128, 2'b01, 1'b1, 1'b1, 5'd6,  32'h0000_BEEF, 1'b1};
    vt[10] = '{3'b100, 32'h0000_B007, 32'h8001_7FFF, 32'h0000_012C, 2'b01, 1'b1, 1'b1, 5'd8,  32'h0000_0080, 1'b1};
    vt[11] = '{3'b101, 32'h0000_C003, 32'h8001_7FFF, 32'h0000_0130, 2'b01, 1'b1, 1'b1, 5'd10, 32'h0000_8001, 1'b1};

    model = '0;
    rst_n = 1'b0;
    bus.EnW_i = 1'b0; bus.FlushW_i = 1'b0; bus.ValidM_i = 1'b0; bus.RegWriteM_i = 1'b0;
    bus.ResultSrcM_i = 2'b00; bus.Funct3M_i = 3'b000; bus.ALUResultM_i = '0;
    bus.ReadDataM_i = '0; bus.PCPlus4M_i = '0; bus.RdM_i = 5'd0;

    // Power-on reset state
    repeat (2) @(negedge clk);
    check_state("reset_state", snap(), '0);
    rst_n = 1'b1;

    // Load extension, x0 gating, valid gating across the table
    for (int i = 0; i < 12; i++) drive_edge(1'b1, 1'b0, vt[i]);

    // Three stall cycles with different inputs: everything frozen
    for (int i = 0; i < 3; i++) drive_edge(1'b0, 1'b0, vt[i]);
    // Flush beats enable: control cleared, data held
    drive_edge(1'b1, 1'b1, vt[2]);
    drive_edge(1'b1, 1'b0, vt[5]);
    wait_drain();

    // Asynchronous reset mid-cycle, checked before any clock edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_state("async_reset", snap(), '0);
    model = '0;
    // Reset dominates an enabled valid instruction
    bus.EnW_i = 1'b1; bus.ValidM_i = 1'b1; bus.RegWriteM_i = 1'b1; bus.RdM_i = 5'd12;
    repeat (2) @(posedge clk);
    #2;
    check_state("reset_priority", snap(), '0);

    // Release reset during a stall: state stays zero until an enabled edge
    @(negedge clk);
    bus.EnW_i = 1'b0;
    rst_n = 1'b1;
    drive_edge(1'b0, 1'b0, vt[6]);
    drive_edge(1'b0, 1'b0, vt[7]);

    // Ten valid enabled edges, two stalls, one flush
    for (int i = 0; i < 12; i++) begin
      if (i != 4 && i != 11) drive_edge(1'b1, 1'b0, vt[i]);
    end
    drive_edge(1'b0, 1'b0, vt[0]);
    drive_edge(1'b0, 1'b0, vt[1]);
    drive_edge(1'b1, 1'b1, vt[2]);
    wait_drain();
`ifdef MEMWB_INSTRET_EN
    check_val("instret_10", bus.InstRetW_o, 64'd10);
    @(negedge clk);
    force u_dut.instret_q = '1;
    #1;
    release u_dut.instret_q;
    check_val("instret_preload", bus.InstRetW_o, {CNT_W{1'b1}});
    model.instret = '1;
    drive_edge(1'b1, 1'b0, vt[3]);
    wait_drain();
    check_val("instret_wrap", bus.InstRetW_o, 64'd0);
`else
    check_val("last_rd_after_flush", {59'd0, bus.RdW_o}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
